cu_read_stream_engine: RTL and testbench

// - Upstream command generator for the memcpy compute unit: walks a source array and issues naturally aligned

---
 rtl/cu_read_stream_engine_pkg.sv | 54 +++++
 rtl/cu_read_stream_engine.sv | 128 ++++++++++++
 tb/tb_cu_read_stream_engine.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/cu_read_stream_engine_pkg.sv
// Shared types for the memcpy CU read stream: command layout, stream states and the
// alignment-aware command sizing rule.
package cu_read_stream_engine_pkg;

    localparam int CU_ID_WIDTH = 8;

    typedef logic [CU_ID_WIDTH-1:0] cu_id_t;

    typedef enum logic [1:0] {
        STRUCT_INVALID = 2'd0,
        READ_DATA      = 2'd1,
        WRITE_DATA     = 2'd2,
        READ_PREFETCH  = 2'd3
    } array_struct_type;

    typedef enum logic [3:0] {
        READ_STREAM_RESET          = 4'd0,
        READ_STREAM_IDLE           = 4'd1,
        READ_STREAM_SET            = 4'd2,
        READ_STREAM_START          = 4'd3,
        READ_STREAM_REQ            = 4'd4,
        READ_STREAM_PENDING        = 4'd5,
        READ_STREAM_DONE           = 4'd6,
        READ_STREAM_FINAL          = 4'd7,
        READ_STREAM_PREFETCH_IDLE  = 4'd8,
        READ_STREAM_PREFETCH_REQ   = 4'd9,
        READ_STREAM_PREFETCH_DONE  = 4'd10
    } read_state;

    typedef struct packed {
        cu_id_t           cu_id;
        array_struct_type cmd_type;
        logic [0:63]      address;
        logic [0:11]      size;
    } ReadCommand;

    // Candidate sizes are monotone (any size that works implies every smaller one does),
    // so the last power of two passing all three limits is the largest legal one.
    function automatic logic [11:0] cmd_size_aligned(input logic [63:0] address,
                                                     input logic [39:0] remaining_bytes,
                                                     input int unsigned max_bytes);
        logic [11:0] size;
        size = '0;
        for (int i = 0; i < 12; i++) begin
            if (((40'(1) << i) <= remaining_bytes) &&
                ((64'(1) << i) <= 64'(max_bytes)) &&
                ((address & ((64'(1) << i) - 64'(1))) == '0)) begin
                size = 12'(1) << i;
            end
        end
        return size;
    endfunction

endpackage

// File: rtl/cu_read_stream_engine.sv
// Walks a source array and issues naturally aligned power-of-two read commands,
// throttled by an outstanding-read credit limit; signals done once all reads return.
module cu_read_stream_engine
    import cu_read_stream_engine_pkg::*;
#(
    parameter int ARRAY_SIZE      = 4,
    parameter int CACHELINE_BYTES = 128,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                                 clock,
    input  logic                                 rstn,
    input  logic                                 enabled_in,
    input  logic                                 start_in,
    input  cu_id_t                               cu_id_in,
    input  logic [63:0]                          src_address_in,
    input  logic [31:0]                          num_elements_in,
    output logic                                 cmd_valid_out,
    input  logic                                 cmd_ready_in,
    output ReadCommand                           cmd_out,
    input  logic                                 rsp_valid_in,
    output logic [$clog2(MAX_OUTSTANDING):0]     outstanding_out,
    output logic                                 done_out
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [OUT_W-1:0] MAX_COUNT = OUT_W'(MAX_OUTSTANDING);

    read_state   state;
    logic [63:0] address;
    logic [39:0] remaining_bytes;
    cu_id_t      latched_cu_id;
    logic [11:0] next_size;
    logic        handshake;
    logic        rsp_accept;

    assign next_size  = cmd_size_aligned(address, remaining_bytes, CACHELINE_BYTES);
    assign handshake  = cmd_valid_out && cmd_ready_in;
    assign rsp_accept = rsp_valid_in && (outstanding_out != '0) && (state != READ_STREAM_RESET);

    // A simultaneous issue and response cancel out; a response with nothing in flight is dropped.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            outstanding_out <= '0;
        end else if (!enabled_in) begin
            outstanding_out <= '0;
        end else if (handshake && !rsp_accept) begin
            outstanding_out <= outstanding_out + 1'b1;
        end else if (!handshake && rsp_accept) begin
            outstanding_out <= outstanding_out - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state           <= READ_STREAM_RESET;
            cmd_valid_out   <= 1'b0;
            cmd_out         <= '0;
            done_out        <= 1'b0;
            address         <= '0;
            remaining_bytes <= '0;
            latched_cu_id   <= '0;
        end else if (!enabled_in) begin
            state         <= READ_STREAM_RESET;
            cmd_valid_out <= 1'b0;
            cmd_out       <= '0;
            done_out      <= 1'b0;
        end else begin
            case (state)
                READ_STREAM_RESET: begin
                    state <= READ_STREAM_IDLE;
                end
                READ_STREAM_IDLE: begin
                    if (start_in) state <= READ_STREAM_SET;
                end
                READ_STREAM_SET: begin
                    address         <= src_address_in;
                    remaining_bytes <= 40'(num_elements_in) * 40'(ARRAY_SIZE);
                    latched_cu_id   <= cu_id_in;
                    done_out        <= 1'b0;
                    state           <= READ_STREAM_START;
                end
                READ_STREAM_START: begin
                    if (remaining_bytes == '0) begin
                        done_out <= 1'b1;
                        state    <= READ_STREAM_DONE;
                    end else begin
                        state <= READ_STREAM_REQ;
                    end
                end
                // The command is frozen in cmd_out while valid, so the advance uses its size field.
                READ_STREAM_REQ: begin
                    if (!cmd_valid_out) begin
                        cmd_valid_out <= 1'b1;
                        cmd_out       <= '{cu_id: latched_cu_id, cmd_type: READ_DATA,
                                           address: address, size: next_size};
                    end else if (cmd_ready_in) begin
                        cmd_valid_out   <= 1'b0;
                        address         <= address + 64'(cmd_out.size);
                        remaining_bytes <= remaining_bytes - 40'(cmd_out.size);
                        state           <= READ_STREAM_PENDING;
                    end
                end
                READ_STREAM_PENDING: begin
                    if ((remaining_bytes != '0) && (outstanding_out < MAX_COUNT)) begin
                        state <= READ_STREAM_REQ;
                    end else if ((remaining_bytes == '0) && (outstanding_out == '0)) begin
                        done_out <= 1'b1;
                        state    <= READ_STREAM_DONE;
                    end
                end
                READ_STREAM_DONE: begin
                    done_out <= 1'b1;
                    state    <= READ_STREAM_FINAL;
                end
                READ_STREAM_FINAL: begin
                    done_out <= 1'b1;
                    if (start_in) state <= READ_STREAM_SET;
                end
                default: begin
                    cmd_valid_out <= 1'b0;
                    done_out      <= 1'b0;
                    state         <= READ_STREAM_RESET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cu_read_stream_engine.sv
// Randomized bench for cu_read_stream_engine: an expected-command queue built from the
// sizing rule plus an outstanding-count model score every handshake and cycle.
module tb_cu_read_stream_engine;
    import cu_read_stream_engine_pkg::*;

    localparam int ARRAY_SIZE      = 4;
    localparam int CACHELINE_BYTES = 128;
    localparam int MAX_OUTSTANDING = 16;

    logic        clock = 1'b0;
    logic        rstn;
    logic        enabled_in;
    logic        start_in;
    cu_id_t      cu_id_in;
    logic [63:0] src_address_in;
    logic [31:0] num_elements_in;
    logic        cmd_valid_out;
    logic        cmd_ready_in;
    ReadCommand  cmd_out;
    logic        rsp_valid_in;
    logic [4:0]  outstanding_out;
    logic        done_out;

    int tests_run    = 0;
    int tests_failed = 0;

    ReadCommand expected_q[$];
    int         model_out     = 0;
    int         accepted      = 0;
    int         ready_pct     = 100;
    int         rsp_pct       = 0;
    logic       en_next       = 1'b0;
    logic       start_next    = 1'b0;
    logic       stall_pending = 1'b0;
    ReadCommand stall_cmd;

    always #5 clock = ~clock;

    cu_read_stream_engine #(
        .ARRAY_SIZE(ARRAY_SIZE),
        .CACHELINE_BYTES(CACHELINE_BYTES),
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) dut (
        .clock(clock),
        .rstn(rstn),
        .enabled_in(enabled_in),
        .start_in(start_in),
        .cu_id_in(cu_id_in),
        .src_address_in(src_address_in),
        .num_elements_in(num_elements_in),
        .cmd_valid_out(cmd_valid_out),
        .cmd_ready_in(cmd_ready_in),
        .cmd_out(cmd_out),
        .rsp_valid_in(rsp_valid_in),
        .outstanding_out(outstanding_out),
        .done_out(done_out)
    );

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Greedy split: biggest power of two within the cacheline that the address alignment allows.
    task automatic buildCommands(input longint unsigned addr, input int unsigned nelem, input cu_id_t id);
        longint unsigned a;
        longint unsigned rem;
        longint unsigned p;
        ReadCommand      c;
        expected_q.delete();
        a   = addr;
        rem = longint'(nelem) * ARRAY_SIZE;
        while (rem > 0) begin
            p = CACHELINE_BYTES;
            while (p > rem || (a % p) != 0) p = p / 2;
            c.cu_id    = id;
            c.cmd_type = READ_DATA;
            c.address  = a;
            c.size     = 12'(p);
            expected_q.push_back(c);
            a   = a + p;
            rem = rem - p;
        end
    endtask

    task automatic step();
        logic hs;
        int   dec;
        @(negedge clock);
        checkOutput("outstanding", 128'(outstanding_out), 128'(model_out));
        if (stall_pending) checkOutput("stall_stable", 128'(cmd_out), 128'(stall_cmd));
        enabled_in   = en_next;
        start_in     = start_next;
        cmd_ready_in = ($urandom_range(0, 99) < ready_pct);
        rsp_valid_in = ($urandom_range(0, 99) < rsp_pct);
        hs = enabled_in && cmd_valid_out && cmd_ready_in;
        if (hs) begin
            accepted++;
            if (expected_q.size() == 0) checkOutput("unexpected_cmd", 128'(cmd_valid_out), 128'(0));
            else checkOutput("cmd", 128'(cmd_out), 128'(expected_q.pop_front()));
        end
        stall_pending = enabled_in && cmd_valid_out && !cmd_ready_in;
        stall_cmd     = cmd_out;
        dec = (rsp_valid_in && model_out > 0) ? 1 : 0;
        if (!enabled_in) model_out = 0;
        else model_out = model_out + (hs ? 1 : 0) - dec;
    endtask

    task automatic applyStimulus(input longint unsigned addr, input int unsigned nelem, input cu_id_t id);
        src_address_in  = addr;
        num_elements_in = nelem;
        cu_id_in        = id;
        accepted        = 0;
        buildCommands(addr, nelem, id);
        start_next = 1'b1;
        step();
        start_next = 1'b0;
        step();
        step();
        checkOutput("done_cleared", 128'(done_out), 128'(0));
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (!done_out && n < budget) begin
            step();
            n++;
        end
        checkOutput("done", 128'(done_out), 128'(1));
        checkOutput("cmds_left", 128'(expected_q.size()), 128'(0));
        checkOutput("idle_outstanding", 128'(outstanding_out), 128'(0));
    endtask

    initial begin
        int n;
        rstn            = 1'b0;
        enabled_in      = 1'b0;
        start_in        = 1'b0;
        cmd_ready_in    = 1'b0;
        rsp_valid_in    = 1'b0;
        cu_id_in        = '0;
        src_address_in  = '0;
        num_elements_in = '0;
        repeat (2) @(negedge clock);
        checkOutput("rst_valid", 128'(cmd_valid_out), 128'(0));
        checkOutput("rst_cmd", 128'(cmd_out), 128'(0));
        checkOutput("rst_outstanding", 128'(outstanding_out), 128'(0));
        checkOutput("rst_done", 128'(done_out), 128'(0));
        rstn    = 1'b1;
        en_next = 1'b1;
        repeat (3) step();

        // two full cachelines
        ready_pct = 100; rsp_pct = 40;
        applyStimulus(64'h1000, 64, 8'h11);
        waitDone(500);

        // misaligned start splits into 4/8/8
        ready_pct = 70; rsp_pct = 40;
        applyStimulus(64'h1004, 5, 8'h22);
        waitDone(500);

        // empty stream: done two cycles after start, never a command
        ready_pct = 100; rsp_pct = 0;
        applyStimulus(64'h1000, 0, 8'h33);
        checkOutput("zero_no_valid", 128'(cmd_valid_out), 128'(0));
        step();
        checkOutput("zero_done", 128'(done_out), 128'(1));
        checkOutput("zero_no_valid2", 128'(cmd_valid_out), 128'(0));

        // arbiter stall of five cycles on the first command
        ready_pct = 0; rsp_pct = 0;
        applyStimulus(64'h3000, 8, 8'h44);
        n = 0;
        while (!cmd_valid_out && n < 20) begin step(); n++; end
        checkOutput("stall_valid", 128'(cmd_valid_out), 128'(1));
        repeat (5) step();
        checkOutput("stall_accepted", 128'(accepted), 128'(0));
        ready_pct = 100;
        step();
        checkOutput("stall_one", 128'(accepted), 128'(1));
        rsp_pct = 50;
        waitDone(500);

        // credit limit with responses withheld
        ready_pct = 100; rsp_pct = 0;
        applyStimulus(64'h4000, 40 * CACHELINE_BYTES / ARRAY_SIZE, 8'h55);
        repeat (200) step();
        checkOutput("throttle_count", 128'(accepted), 128'(MAX_OUTSTANDING));
        checkOutput("throttle_valid", 128'(cmd_valid_out), 128'(0));
        checkOutput("throttle_outstanding", 128'(outstanding_out), 128'(MAX_OUTSTANDING));
        rsp_pct = 100;
        step();
        rsp_pct = 0;
        repeat (10) step();
        checkOutput("throttle_resume", 128'(accepted), 128'(MAX_OUTSTANDING + 1));
        rsp_pct = 60;
        waitDone(3000);

        // abort with three reads in flight
        ready_pct = 100; rsp_pct = 0;
        applyStimulus(64'h8000, 40 * CACHELINE_BYTES / ARRAY_SIZE, 8'h66);
        n = 0;
        while (accepted < 3 && n < 100) begin step(); n++; end
        checkOutput("abort_reach3", 128'(accepted), 128'(3));
        ready_pct = 0;
        en_next   = 1'b0;
        step();
        step();
        checkOutput("abort_valid", 128'(cmd_valid_out), 128'(0));
        checkOutput("abort_done", 128'(done_out), 128'(0));
        ready_pct = 100; rsp_pct = 50;
        for (int i = 0; i < 10; i++) begin
            step();
            checkOutput("abort_quiet", 128'(cmd_valid_out), 128'(0));
        end
        checkOutput("abort_accepted", 128'(accepted), 128'(3));
        expected_q.delete();
        en_next = 1'b1;
        repeat (3) step();

        // randomized streams
        for (int s = 0; s < 10; s++) begin
            ready_pct = $urandom_range(30, 100);
            rsp_pct   = $urandom_range(20, 90);
            applyStimulus(64'h1_0000_0000 + 64'($urandom_range(0, 32'hFFFF) * 4),
                          $urandom_range(0, 100), 8'($urandom));
            waitDone(4000);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
